// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: redirect kinds and the fetch step size.
package pc_pkg;

    typedef enum logic [1:0] {
        KIND_BRANCH = 2'd0,
        KIND_JUMP   = 2'd1,
        KIND_CALL   = 2'd2,
        KIND_RETURN = 2'd3
    } redirect_kind_e;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer in which a push onto a full stack overwrites the oldest entry.
module pc_ras #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [PTR_W-1:0]  top_idx;

    // ptr_reg points at the next free slot; the top of stack sits just below it.
    assign top_idx = ptr_reg - PTR_W'(1);
    assign dout    = mem[top_idx];
    assign empty   = (cnt_reg == '0);

    always_ff @(posedge clock) begin
        if (push) begin
            mem[ptr_reg] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_reg <= '0;
            cnt_reg <= '0;
        end else if (push) begin
            ptr_reg <= ptr_reg + PTR_W'(1);
            if (cnt_reg != CNT_W'(DEPTH)) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_reg <= top_idx;
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch address sequencer with redirects, stall and sticky misalignment fault.
// Define PC_SEQUENCER_RAS_EN to compile in the return-address stack for call/return.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int RESET_VEC = 0,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [1:0]        redirect_kind,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] address,
    output logic              address_valid,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr
);

    logic [ADDR_W-1:0] address_reg, address_next;
    logic              valid_reg, valid_next;
    logic              fault_reg, fault_next;
    logic [ADDR_W-1:0] fault_addr_reg, fault_addr_next;
    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] sel_addr;
    logic              misaligned;

    assign seq_addr   = address_reg + ADDR_W'(PC_STEP);
    assign misaligned = |sel_addr[1:0];

`ifdef PC_SEQUENCER_RAS_EN
    redirect_kind_e    kind;
    logic              ras_push, ras_pop, ras_empty;
    logic [ADDR_W-1:0] ras_dout;
    logic              accept;

    assign kind   = redirect_kind_e'(redirect_kind);
    assign accept = redirect_valid && !fault_reg && !reset && !misaligned;
    // Call pushes the address after itself; return only pops when something is there.
    assign ras_push = accept && (kind == KIND_CALL);
    assign ras_pop  = accept && (kind == KIND_RETURN) && !ras_empty;

    always_comb begin
        sel_addr = redirect_target;
        if (kind == KIND_RETURN && !ras_empty) begin
            sel_addr = ras_dout;
        end
    end

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clock (clock),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (seq_addr),
        .dout  (ras_dout),
        .empty (ras_empty)
    );
`else
    // Every redirect kind behaves as a jump; kind and stack depth are intentionally unused.
    logic unused_cfg;
    assign unused_cfg = ^redirect_kind ^ (RAS_DEPTH != 0);
    assign sel_addr   = redirect_target;
`endif

    always_comb begin
        address_next    = address_reg;
        valid_next      = valid_reg;
        fault_next      = fault_reg;
        fault_addr_next = fault_addr_reg;
        if (fault_reg) begin
            valid_next = 1'b0;
        end else if (redirect_valid) begin
            if (misaligned) begin
                fault_next      = 1'b1;
                fault_addr_next = sel_addr;
                valid_next      = 1'b0;
            end else begin
                address_next = sel_addr;
                valid_next   = 1'b1;
            end
        end else if (stall) begin
            valid_next = 1'b1;
        end else begin
            address_next = seq_addr;
            valid_next   = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            address_reg    <= ADDR_W'(RESET_VEC);
            valid_reg      <= 1'b0;
            fault_reg      <= 1'b0;
            fault_addr_reg <= '0;
        end else begin
            address_reg    <= address_next;
            valid_reg      <= valid_next;
            fault_reg      <= fault_next;
            fault_addr_reg <= fault_addr_next;
        end
    end

    assign address       = address_reg;
    assign address_valid = valid_reg;
    assign fault         = fault_reg;
    assign fault_addr    = fault_addr_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer; expectations follow the RAS build when PC_SEQUENCER_RAS_EN is defined.
module tb_pc_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       stall;
    logic       redirect_valid;
    logic [1:0] redirect_kind;
    logic [7:0] redirect_target;
    logic [7:0] address;
    logic       address_valid;
    logic       fault;
    logic [7:0] fault_addr;

    typedef struct {
        int         id;
        logic [7:0] addr;
        logic       valid;
        logic       flt;
        logic [7:0] faddr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_id  = 0;

    localparam logic [1:0] BR = 2'd0, JP = 2'd1, CL = 2'd2, RT = 2'd3;

    always #5 clock = ~clock;

    pc_sequencer #(
        .ADDR_W    (8),
        .RESET_VEC (0),
        .RAS_DEPTH (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_kind   (redirect_kind),
        .redirect_target (redirect_target),
        .address         (address),
        .address_valid   (address_valid),
        .fault           (fault),
        .fault_addr      (fault_addr)
    );

    // Monitor: the DUT presents a registered result every cycle; pop and compare on the falling edge.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (address !== e.addr || address_valid !== e.valid ||
                fault !== e.flt || fault_addr !== e.faddr) begin
                failures++;
                $display("FAIL step%0d: got addr=%02h valid=%0b fault=%0b fault_addr=%02h want addr=%02h valid=%0b fault=%0b fault_addr=%02h",
                         e.id, address, address_valid, fault, fault_addr,
                         e.addr, e.valid, e.flt, e.faddr);
            end else begin
                $display("step%0d ok: addr=%02h valid=%0b fault=%0b fault_addr=%02h",
                         e.id, address, address_valid, fault, fault_addr);
            end
        end
    end

    task automatic step(input logic rst, input logic stl, input logic rv,
                        input logic [1:0] kind, input logic [7:0] tgt,
                        input logic [7:0] ea, input logic ev, input logic ef,
                        input logic [7:0] efa);
        exp_t e;
        reset           = rst;
        stall           = stl;
        redirect_valid  = rv;
        redirect_kind   = kind;
        redirect_target = tgt;
        @(posedge clock);
        #1;
        e.id = step_id; e.addr = ea; e.valid = ev; e.flt = ef; e.faddr = efa;
        exp_q.push_back(e);
        step_id++;
        @(negedge clock);
    endtask

    task automatic run(input logic [7:0] ea);
        step(1'b0, 1'b0, 1'b0, BR, 8'h00, ea, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic redir(input logic stl, input logic [1:0] kind, input logic [7:0] tgt,
                         input logic [7:0] ea);
        step(1'b0, stl, 1'b1, kind, tgt, ea, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        redirect_kind = BR; redirect_target = 8'h00;
        @(negedge clock);

        // Reset state, then free-running from the reset vector.
        step(1'b1, 1'b0, 1'b0, BR, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, JP, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00);
        run(8'h04); run(8'h08); run(8'h0C); run(8'h10);

        // Stall holds; a redirect wins over stall with one cycle of latency.
        step(1'b0, 1'b1, 1'b0, BR, 8'h00, 8'h10, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, BR, 8'h00, 8'h10, 1'b1, 1'b0, 8'h00);
        redir(1'b1, JP, 8'h40, 8'h40);
        run(8'h44);

        // Wrap past the top of the address space with no fault.
        redir(1'b0, BR, 8'hF8, 8'hF8);
        run(8'hFC); run(8'h00); run(8'h04); run(8'h08);

        // Call at 0x08, later return.
`ifdef PC_SEQUENCER_RAS_EN
        redir(1'b0, CL, 8'h80, 8'h80);
        run(8'h84);
        redir(1'b0, RT, 8'h00, 8'h0C);
        run(8'h10);
        // Five calls overflow a 4-deep stack; the oldest return address (0x14) is lost.
        redir(1'b0, CL, 8'h40, 8'h40);
        redir(1'b0, CL, 8'h50, 8'h50);
        redir(1'b0, CL, 8'h60, 8'h60);
        redir(1'b0, CL, 8'h70, 8'h70);
        redir(1'b0, CL, 8'h80, 8'h80);
        redir(1'b0, RT, 8'hA0, 8'h74);
        redir(1'b0, RT, 8'hA0, 8'h64);
        redir(1'b0, RT, 8'hA0, 8'h54);
        redir(1'b0, RT, 8'hA0, 8'h44);
        redir(1'b0, RT, 8'hA0, 8'hA0);
`else
        redir(1'b0, CL, 8'h80, 8'h80);
        run(8'h84);
        redir(1'b0, RT, 8'h00, 8'h00);
        run(8'h04);
        redir(1'b0, CL, 8'h40, 8'h40);
        redir(1'b0, CL, 8'h50, 8'h50);
        redir(1'b0, CL, 8'h60, 8'h60);
        redir(1'b0, CL, 8'h70, 8'h70);
        redir(1'b0, CL, 8'h80, 8'h80);
        redir(1'b0, RT, 8'hA0, 8'hA0);
        redir(1'b0, RT, 8'hA4, 8'hA4);
        redir(1'b0, RT, 8'hA8, 8'hA8);
        redir(1'b0, RT, 8'h9C, 8'h9C);
        redir(1'b0, RT, 8'hA0, 8'hA0);
`endif
        run(8'hA4);

        // Misaligned branch faults; everything but reset is then ignored.
        step(1'b0, 1'b0, 1'b1, BR, 8'h22, 8'hA4, 1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b0, 1'b1, JP, 8'h40, 8'hA4, 1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b0, 1'b1, CL, 8'h81, 8'hA4, 1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b0, 1'b0, BR, 8'h00, 8'hA4, 1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b1, 1'b0, BR, 8'h00, 8'hA4, 1'b0, 1'b1, 8'h22);

        // Reset mid-fault with a redirect present clears everything.
        step(1'b1, 1'b1, 1'b1, JP, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, BR, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        run(8'h04);
        redir(1'b0, JP, 8'hFC, 8'hFC);
        run(8'h00);

        repeat (3) @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected results left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
